alu_operand_sequencer: RTL and testbench



---
 rtl/alu_operand_sequencer_if.sv | 26 ++
 rtl/alu_operand_sequencer.sv | 89 ++++++++
 tb/tb_alu_operand_sequencer.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/alu_operand_sequencer_if.sv
// alu_operand_sequencer_if: switch/button inputs, ALU operand/op/result bus and display outputs
interface alu_operand_sequencer_if;
  logic       btn;
  logic [6:0] sw;
  logic [1:0] op_sel;
  logic [6:0] alu_a;
  logic [6:0] alu_b;
  logic [1:0] alu_op;
  logic [6:0] alu_result;
  logic       alu_overflow;
  logic       alu_zero;
  logic       alu_carry;
  logic       alu_negative;
  logic [6:0] res_q;
  logic [3:0] flags_q;
  logic       done;
  logic [2:0] state_o;
  modport master (
    input  btn, sw, op_sel, alu_result, alu_overflow, alu_zero, alu_carry, alu_negative,
    output alu_a, alu_b, alu_op, res_q, flags_q, done, state_o
  );
  modport slave (
    output btn, sw, op_sel, alu_result, alu_overflow, alu_zero, alu_carry, alu_negative,
    input  alu_a, alu_b, alu_op, res_q, flags_q, done, state_o
  );
endinterface

// File: rtl/alu_operand_sequencer.sv
// alu_operand_sequencer: debounced button steps A/B/op loading, executes the ALU and captures its result
package Decoders;
  typedef enum logic [1:0] {ADD = 2'b00, SUB = 2'b01, AND = 2'b10, OR = 2'b11} OP_t;
endpackage

module alu_operand_sequencer #(
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input logic clk,
  input logic rst,
  alu_operand_sequencer_if.master bus
);
  import Decoders::*;
  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  typedef enum logic [2:0] {LOAD_A = 3'd0, LOAD_B = 3'd1, LOAD_OP = 3'd2, EXEC = 3'd3, SHOW = 3'd4} state_t;
  logic             sync1_q, sync2_q, lvl_q, lvl_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             diff, flip, press;
  state_t           state_q, state_d;
  logic [6:0]       a_q, a_d, b_q, b_d, res_q, res_d;
  OP_t              op_q, op_d;
  logic [3:0]       flags_q, flags_d;
  logic             done_q, done_d;
  always_comb begin
    diff  = sync2_q ^ lvl_q;
    flip  = diff && cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1);
    cnt_d = (diff && !flip) ? cnt_q + CNT_W'(1) : '0;
    lvl_d = flip ? ~lvl_q : lvl_q;
    press = flip & ~lvl_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      cnt_q   <= '0;
      lvl_q   <= 1'b1;
      state_q <= LOAD_A;
    end else begin
      sync1_q <= bus.btn;
      sync2_q <= sync1_q;
      cnt_q   <= cnt_d;
      lvl_q   <= lvl_d;
      state_q <= state_d;
    end
  end
  always_comb begin
    state_d = LOAD_A;
    case (state_q)
      LOAD_A:  state_d = press ? LOAD_B : LOAD_A;
      LOAD_B:  state_d = press ? LOAD_OP : LOAD_B;
      LOAD_OP: state_d = press ? EXEC : LOAD_OP;
      EXEC:    state_d = SHOW;
      SHOW:    state_d = press ? LOAD_A : SHOW;
      default: state_d = LOAD_A;
    endcase
  end
  always_comb begin
    a_d     = (state_q == LOAD_A && press) ? bus.sw : a_q;
    b_d     = (state_q == LOAD_B && press) ? bus.sw : b_q;
    op_d    = (state_q == LOAD_OP && press) ? OP_t'(bus.op_sel) : op_q;
    res_d   = (state_q == EXEC) ? bus.alu_result : res_q;
    flags_d = (state_q == EXEC) ? {bus.alu_overflow, bus.alu_zero, bus.alu_carry, bus.alu_negative} : flags_q;
    done_d  = (state_q == EXEC) ? 1'b1 : (state_q == SHOW && press) ? 1'b0 : done_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= ADD;
      res_q   <= '0;
      flags_q <= '0;
      done_q  <= 1'b0;
    end else begin
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      res_q   <= res_d;
      flags_q <= flags_d;
      done_q  <= done_d;
    end
  end
  assign bus.alu_a   = a_q;
  assign bus.alu_b   = b_q;
  assign bus.alu_op  = op_q;
  assign bus.res_q   = res_q;
  assign bus.flags_q = flags_q;
  assign bus.done    = done_q;
  assign bus.state_o = state_q;
endmodule

// File: tb/tb_alu_operand_sequencer.sv
// tb_alu_operand_sequencer: directed press sequences checked every settled cycle against a load/execute model
module tb_alu_operand_sequencer;
  localparam logic [1:0] ADD = 2'b00, SUB = 2'b01, AND_OP = 2'b10, OR_OP = 2'b11;
  logic clk = 1'b0;
  logic rst;
  logic settled;
  int   tests = 0;
  int   fails = 0;
  logic [2:0] m_state;
  logic [6:0] m_a, m_b, m_res;
  logic [1:0] m_op;
  logic [3:0] m_flags;
  logic       m_done;
  always #5 clk = ~clk;
  alu_operand_sequencer_if bus();
  alu_operand_sequencer #(.DEBOUNCE_CYCLES(4)) dut (.clk(clk), .rst(rst), .bus(bus));
  function automatic logic [10:0] alu_fn(input logic [6:0] a, input logic [6:0] b, input logic [1:0] op);
    logic [7:0] s;
    logic       v, c;
    s = 8'h00;
    v = 1'b0;
    c = 1'b0;
    if (op == ADD) begin
      s = {1'b0, a} + {1'b0, b};
      c = s[7];
      v = (a[6] == b[6]) && (s[6] != a[6]);
    end else if (op == SUB) begin
      s = {1'b0, a} + {1'b0, ~b} + 8'd1;
      c = s[7];
      v = (a[6] != b[6]) && (s[6] != a[6]);
    end else if (op == AND_OP) s = {1'b0, a & b};
    else s = {1'b0, a | b};
    return {v, s[6:0] == 7'd0, c, s[6], s[6:0]};
  endfunction
  always_comb {bus.alu_overflow, bus.alu_zero, bus.alu_carry, bus.alu_negative, bus.alu_result} = alu_fn(bus.alu_a, bus.alu_b, bus.alu_op);
  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask
  task automatic model_reset();
    m_state = 3'd0; m_a = '0; m_b = '0; m_op = ADD; m_res = '0; m_flags = '0; m_done = 1'b0;
  endtask
  task automatic model_press();
    if (m_state == 3'd0) begin m_a = bus.sw; m_state = 3'd1; end
    else if (m_state == 3'd1) begin m_b = bus.sw; m_state = 3'd2; end
    else if (m_state == 3'd2) begin
      m_op = bus.op_sel;
      {m_flags, m_res} = alu_fn(m_a, m_b, m_op);
      m_done = 1'b1;
      m_state = 3'd4;
    end else begin m_done = 1'b0; m_state = 3'd0; end
  endtask
  always @(negedge clk) begin
    if (settled) begin
      chk("state", {5'd0, bus.state_o}, {5'd0, m_state});
      chk("alu_a", {1'b0, bus.alu_a}, {1'b0, m_a});
      chk("alu_b", {1'b0, bus.alu_b}, {1'b0, m_b});
      chk("alu_op", {6'd0, bus.alu_op}, {6'd0, m_op});
      chk("res_q", {1'b0, bus.res_q}, {1'b0, m_res});
      chk("flags_q", {4'd0, bus.flags_q}, {4'd0, m_flags});
      chk("done", {7'd0, bus.done}, {7'd0, m_done});
    end
  end
  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic press();
    settled = 1'b0;
    bus.btn = 1'b1;
    cyc(10);
    bus.btn = 1'b0;
    cyc(10);
    model_press();
    settled = 1'b1;
  endtask
  task automatic load(input logic [6:0] a, input logic [6:0] b, input logic [1:0] op);
    bus.sw = a;
    press();
    bus.sw = b;
    press();
    bus.op_sel = op;
    press();
  endtask
  initial begin
    settled = 1'b0;
    rst = 1'b1;
    bus.btn = 1'b0;
    bus.sw = '0;
    bus.op_sel = ADD;
    model_reset();
    cyc(3);
    settled = 1'b1;
    cyc(1);
    chk("reset_state", {5'd0, bus.state_o}, 8'h00);
    chk("reset_done", {7'd0, bus.done}, 8'h00);
    rst = 1'b0;
    cyc(10);
    load(7'h05, 7'h03, ADD);
    chk("add_res", {1'b0, bus.res_q}, 8'h08);
    chk("add_flags", {4'd0, bus.flags_q}, 8'h00);
    chk("add_done", {7'd0, bus.done}, 8'h01);
    chk("add_state", {5'd0, bus.state_o}, 8'h04);
    bus.sw = 7'h7A;
    cyc(5);
    chk("show_sw_a", {1'b0, bus.alu_a}, 8'h05);
    chk("show_sw_b", {1'b0, bus.alu_b}, 8'h03);
    press();
    chk("ack_done", {7'd0, bus.done}, 8'h00);
    chk("ack_state", {5'd0, bus.state_o}, 8'h00);
    chk("ack_res", {1'b0, bus.res_q}, 8'h08);
    load(7'h40, 7'h01, SUB);
    chk("sub_res", {1'b0, bus.res_q}, 8'h3F);
    chk("sub_flags", {4'd0, bus.flags_q}, 8'h0A);
    press();
    load(7'h7F, 7'h01, ADD);
    chk("wrap_res", {1'b0, bus.res_q}, 8'h00);
    chk("wrap_flags", {4'd0, bus.flags_q}, 8'h06);
    press();
    load(7'h55, 7'h0F, AND_OP);
    chk("and_res", {1'b0, bus.res_q}, 8'h05);
    chk("and_flags", {4'd0, bus.flags_q}, 8'h00);
    press();
    load(7'h21, 7'h44, OR_OP);
    chk("or_res", {1'b0, bus.res_q}, 8'h65);
    chk("or_flags", {4'd0, bus.flags_q}, 8'h01);
    press();
    bus.sw = 7'h11;
    bus.btn = 1'b1;
    cyc(2);
    bus.btn = 1'b0;
    cyc(10);
    chk("glitch_state", {5'd0, bus.state_o}, 8'h00);
    chk("glitch_a", {1'b0, bus.alu_a}, 8'h21);
    press();
    chk("clean_state", {5'd0, bus.state_o}, 8'h01);
    chk("clean_a", {1'b0, bus.alu_a}, 8'h11);
    bus.sw = 7'h22;
    press();
    settled = 1'b0;
    bus.btn = 1'b1;
    cyc(1);
    rst = 1'b1;
    cyc(1);
    rst = 1'b0;
    model_reset();
    chk("rst_state", {5'd0, bus.state_o}, 8'h00);
    chk("rst_a", {1'b0, bus.alu_a}, 8'h00);
    chk("rst_b", {1'b0, bus.alu_b}, 8'h00);
    chk("rst_op", {6'd0, bus.alu_op}, 8'h00);
    chk("rst_done", {7'd0, bus.done}, 8'h00);
    settled = 1'b1;
    cyc(20);
    chk("held_state", {5'd0, bus.state_o}, 8'h00);
    bus.btn = 1'b0;
    cyc(10);
    chk("release_state", {5'd0, bus.state_o}, 8'h00);
    bus.sw = 7'h33;
    press();
    chk("repress_state", {5'd0, bus.state_o}, 8'h01);
    chk("repress_a", {1'b0, bus.alu_a}, 8'h33);
    settled = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
